// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the UART receiver's serial input, frame configuration and
// received-word/status outputs.
//   RX_IN       serial line into the receiver (idles high)
//   PAR_EN      1 = frame carries a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last accepted data word
//   DATA_VALID  one-cycle pulse: frame accepted
//   PAR_ERR     one-cycle pulse: parity mismatch
//   STP_ERR     one-cycle pulse: stop bit sampled low
//   Busy        receiver is inside a frame
// The master drives the line and the configuration; the slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             RX_IN;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_ERR;
  logic             STP_ERR;
  logic             Busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
// Each bit spans PRESCALE clk cycles; the bit value is the majority of three
// samples around the bit centre.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   uart_rx_if slave: RX_IN/PAR_EN/PAR_TYP in; P_DATA, DATA_VALID,
//         PAR_ERR, STP_ERR, Busy out (all registered)
module uart_rx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_LO   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] EDGE_MID  = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_HI   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [EW-1:0]    edge_q, edge_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             samp_lo_q, samp_lo_d;
  logic             samp_mid_q, samp_mid_d;
  logic             pen_q, pen_d;
  logic             ptyp_q, ptyp_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             serr_q, serr_d;
  logic             busy_q, busy_d;
  logic             maj_c;
  logic             at_maj_c;
  logic             at_end_c;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // Majority of the two stored centre samples and the current one
  assign maj_c    = (samp_lo_q & samp_mid_q) | (samp_lo_q & rx_s) | (samp_mid_q & rx_s);
  assign at_maj_c = (edge_q == EDGE_HI);
  assign at_end_c = (edge_q == EDGE_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      samp_lo_q  <= samp_lo_d;
      samp_mid_q <= samp_mid_d;
      pen_q      <= pen_d;
      ptyp_q     <= ptyp_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, counters and result evaluation
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    samp_lo_d  = samp_lo_q;
    samp_mid_d = samp_mid_q;
    pen_d      = pen_q;
    ptyp_d     = ptyp_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    busy_d     = busy_q;

    if (state_q != S_IDLE) begin
      edge_d = at_end_c ? '0 : edge_q + EW'(1);
      if (edge_q == EDGE_LO)  samp_lo_d  = rx_s;
      if (edge_q == EDGE_MID) samp_mid_d = rx_s;
    end

    case (state_q)
      S_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s) begin
          state_d = S_START;
          busy_d  = 1'b1;
          pen_d   = bus.PAR_EN;
          ptyp_d  = bus.PAR_TYP;
        end
      end

      S_START: begin
        // A start bit that is high at its centre was a glitch
        if (at_maj_c && maj_c) begin
          state_d = S_IDLE;
          edge_d  = '0;
          busy_d  = 1'b0;
        end else if (at_end_c) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (at_maj_c) shift_d[bit_q] = maj_c;
        if (at_end_c) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      S_PARITY: begin
        if (at_maj_c) par_bit_d = maj_c;
        if (at_end_c) state_d = S_STOP;
      end

      S_STOP: begin
        // Decide at the stop-bit centre so a back-to-back start edge is not missed
        if (at_maj_c) begin
          state_d = S_IDLE;
          edge_d  = '0;
          busy_d  = 1'b0;
          if (!maj_c) begin
            serr_d = 1'b1;
          end else if (pen_q && ((^shift_q ^ par_bit_q) != ptyp_q)) begin
            perr_d = 1'b1;
          end else begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
        bit_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.PAR_ERR    = perr_q;
  assign bus.STP_ERR    = serr_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference
// model; expected results are queued at send time and matched by a monitor.
module tb_uart_rx;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned PRESCALE = 8;

  localparam int K_OK  = 0;
  localparam int K_PAR = 1;
  localparam int K_STP = 2;

  typedef struct {
    int         kind;
    logic [7:0] pdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_if #(.WIDTH(WIDTH)) u_if ();

  uart_rx #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pdata;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame outcome from the protocol rules: stop error wins, then parity
  function automatic int model_kind(input logic [7:0] d, input bit pe, input bit pt,
                                    input bit pb, input bit sb);
    if (!sb) return K_STP;
    if (pe && ((($countones(d) + int'(pb)) % 2) != int'(pt))) return K_PAR;
    return K_OK;
  endfunction

  // Monitor: every result pulse must match the oldest expected frame outcome
  int   mon_n;
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = int'(u_if.DATA_VALID) + int'(u_if.PAR_ERR) + int'(u_if.STP_ERR);
      if (mon_n > 0) begin
        check("one_pulse", mon_n, 1);
        mon_kind = u_if.DATA_VALID ? K_OK : (u_if.PAR_ERR ? K_PAR : K_STP);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d expected none at %0t", mon_kind, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", mon_kind, mon_e.kind);
          check("p_data", int'(u_if.P_DATA), int'(mon_e.pdata));
          check("busy_at_pulse", int'(u_if.Busy), 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    u_if.RX_IN = v;
    tick(PRESCALE);
  endtask

  task automatic idle(input int n);
    u_if.RX_IN = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input bit pb, input bit sb, input bit scramble);
    exp_t e;
    u_if.PAR_EN  = pe;
    u_if.PAR_TYP = pt;
    e.kind = model_kind(d, pe, pt, pb, sb);
    if (e.kind == K_OK) model_pdata = d;
    e.pdata = model_pdata;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (scramble && i == 3) begin
        u_if.PAR_EN  = 1'($urandom_range(0, 1));
        u_if.PAR_TYP = 1'($urandom_range(0, 1));
      end
    end
    if (pe) send_bit(pb);
    send_bit(sb);
  endtask

  task automatic good_frame(input logic [7:0] d, input bit pe, input bit pt);
    bit pb;
    pb = 1'(($countones(d) + int'(pt)) % 2);
    send_frame(d, pe, pt, pb, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 * PRESCALE && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_p_data"}, int'(u_if.P_DATA), 0);
    check({tag, "_valid"},  int'(u_if.DATA_VALID), 0);
    check({tag, "_par_err"}, int'(u_if.PAR_ERR), 0);
    check({tag, "_stp_err"}, int'(u_if.STP_ERR), 0);
    check({tag, "_busy"},   int'(u_if.Busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   busy_cnt;
    logic [7:0] d;
    bit   pe, pt, pb, sb;

    rst          = 1'b1;
    u_if.RX_IN   = 1'b1;
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
    model_pdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * PRESCALE);

    // Plain frame, no parity
    good_frame(8'hA5, 1'b0, 1'b0);
    idle(20);
    drain("drain_a5");

    // Even parity: correct, then wrong parity bit
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);
    drain("drain_parity");

    // Stop-bit error followed by a clean frame
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3 * PRESCALE);
    good_frame(8'h0F, 1'b0, 1'b0);
    idle(20);
    drain("drain_stop");

    // Two-clock low glitch on an idle line
    u_if.RX_IN = 1'b0;
    tick(2);
    u_if.RX_IN = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 4 * PRESCALE; i++) begin
      @(negedge clk);
      if (u_if.Busy) busy_cnt++;
    end
    check("glitch_busy_bounded", int'(busy_cnt <= int'(PRESCALE / 2 + 3)), 1);
    check("glitch_busy_seen", int'(busy_cnt > 0), 1);
    @(posedge clk);
    #1;
    idle(PRESCALE);

    // Back-to-back frames, no idle gap
    good_frame(8'h00, 1'b0, 1'b0);
    good_frame(8'hFF, 1'b0, 1'b0);
    good_frame(8'h81, 1'b0, 1'b0);
    idle(20);
    drain("drain_b2b");

    // Reset in the middle of a frame's data bits
    u_if.PAR_EN = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst        = 1'b1;
    u_if.RX_IN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    @(posedge clk);
    #1;
    rst         = 1'b0;
    model_pdata = '0;
    idle(3 * PRESCALE);
    good_frame(8'hC3, 1'b0, 1'b0);
    idle(20);
    drain("drain_after_reset");

    // Randomized frames, config scrambled mid-frame
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'(($countones(d) + int'(pt)) % 2);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb = ($urandom_range(0, 6) != 0);
      send_frame(d, pe, pt, pb, sb, 1'b1);
      if (!sb) idle(3 * PRESCALE);
      else     idle($urandom_range(0, 3 * PRESCALE));
    end
    idle(20);
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
